// File: rtl/frequency_discriminator.sv
// frequency_discriminator
// Counts reference clocks over a programmable number of carrier periods and
// quantises the count against a ladder of thresholds. If no carrier edges
// arrive before the period counter saturates, the block drops back to
// acquisition and flags the loss of signal.
`timescale 1ns/1ps
module frequency_discriminator #(
    parameter int COUNT_BITS  = 16,
    parameter int OUTPUT_BITS = 2,
    parameter int PERIOD_BITS = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk_200M,
    input  logic                   reset_200M,
    input  logic                   input_frequency,
    input  logic [PERIOD_BITS-1:0] periods_i,
    input  logic [COUNT_BITS-1:0]  compare_base_i,
    input  logic [COUNT_BITS-1:0]  compare_step_i,
    output logic [COUNT_BITS-1:0]  sample_o,
    output logic [OUTPUT_BITS-1:0] comparison_o,
    output logic                   sample_valid_o,
    output logic                   no_signal_o
);

    localparam int NUM_LEVELS = 2 ** OUTPUT_BITS;
    // Thresholds are evaluated wide enough that base + j*step never wraps.
    localparam int THR_W      = COUNT_BITS + OUTPUT_BITS + 1;
    localparam logic [COUNT_BITS-1:0] TIMEOUT_CNT = {{(COUNT_BITS-1){1'b1}}, 1'b0};

    typedef enum logic {
        ST_ACQUIRE = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   r_edge;
    logic [COUNT_BITS-1:0]  r_period_cnt;
    logic [PERIOD_BITS-1:0] r_edge_cnt;
    logic [PERIOD_BITS-1:0] r_periods;
    logic [COUNT_BITS-1:0]  r_sample;
    logic [OUTPUT_BITS-1:0] r_comparison;
    logic                   r_sample_valid;
    logic                   r_no_signal;

    logic [COUNT_BITS-1:0]  w_new_sample;
    logic [PERIOD_BITS:0]   w_edge_cnt_nxt;
    logic                   w_complete;
    logic [PERIOD_BITS-1:0] w_periods_lat;
    logic [OUTPUT_BITS-1:0] w_level;

    // Number of thresholds the sample lies strictly below; faster carrier -> higher code.
    function automatic logic [OUTPUT_BITS-1:0] quantise(
        input logic [COUNT_BITS-1:0] sample,
        input logic [COUNT_BITS-1:0] base,
        input logic [COUNT_BITS-1:0] step
    );
        logic [THR_W-1:0]       thr;
        logic [OUTPUT_BITS-1:0] level;
        level = '0;
        for (int j = 0; j < NUM_LEVELS - 1; j++) begin
            thr = THR_W'(base) + THR_W'(j) * THR_W'(step);
            if (THR_W'(sample) < thr) begin
                level = level + OUTPUT_BITS'(1);
            end
        end
        return level;
    endfunction

    assign w_new_sample   = r_period_cnt + COUNT_BITS'(1);
    assign w_edge_cnt_nxt = {1'b0, r_edge_cnt} + (PERIOD_BITS+1)'(1);
    assign w_complete     = r_edge && (w_edge_cnt_nxt == {1'b0, r_periods});
    // A period count of zero would never complete, so treat it as one.
    assign w_periods_lat  = (periods_i == '0) ? PERIOD_BITS'(1) : periods_i;
    assign w_level        = quantise(w_new_sample, compare_base_i, compare_step_i);

    // Synchronise the carrier and register a single-cycle rising-edge strobe.
    always_ff @(posedge clk_200M or posedge reset_200M) begin
        if (reset_200M) begin
            r_sync <= '0;
            r_hist <= 1'b0;
            r_edge <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], input_frequency};
            r_hist <= r_sync[SYNC_STAGES-1];
            r_edge <= r_sync[SYNC_STAGES-1] & ~r_hist;
        end
    end

    // Acquire/measure sequencing, sample capture and loss-of-signal timeout.
    always_ff @(posedge clk_200M or posedge reset_200M) begin
        if (reset_200M) begin
            r_state        <= ST_ACQUIRE;
            r_period_cnt   <= '0;
            r_edge_cnt     <= '0;
            r_periods      <= PERIOD_BITS'(1);
            r_sample       <= '0;
            r_comparison   <= '0;
            r_sample_valid <= 1'b0;
            r_no_signal    <= 1'b1;
        end else begin
            r_sample_valid <= 1'b0;
            case (r_state)
                ST_ACQUIRE: begin
                    r_period_cnt <= '0;
                    r_edge_cnt   <= '0;
                    if (r_edge) begin
                        r_state   <= ST_MEASURE;
                        r_periods <= w_periods_lat;
                    end
                end
                ST_MEASURE: begin
                    if (w_complete) begin
                        // A completing edge wins even on the timeout cycle.
                        r_sample       <= w_new_sample;
                        r_comparison   <= w_level;
                        r_sample_valid <= 1'b1;
                        r_no_signal    <= 1'b0;
                        r_period_cnt   <= '0;
                        r_edge_cnt     <= '0;
                        r_periods      <= w_periods_lat;
                    end else if (r_period_cnt == TIMEOUT_CNT) begin
                        r_state      <= ST_ACQUIRE;
                        r_no_signal  <= 1'b1;
                        r_period_cnt <= '0;
                        r_edge_cnt   <= '0;
                    end else begin
                        r_period_cnt <= r_period_cnt + COUNT_BITS'(1);
                        if (r_edge) begin
                            r_edge_cnt <= w_edge_cnt_nxt[PERIOD_BITS-1:0];
                        end
                    end
                end
                default: r_state <= ST_ACQUIRE;
            endcase
        end
    end

    assign sample_o       = r_sample;
    assign comparison_o   = r_comparison;
    assign sample_valid_o = r_sample_valid;
    assign no_signal_o    = r_no_signal;

endmodule

// File: tb/tb_frequency_discriminator.sv
// tb_frequency_discriminator
// Carrier generator with an event-level reference model feeding a scoreboard;
// a monitor pops expectations on every sample_valid_o pulse.
`timescale 1ns/1ps
module tb_frequency_discriminator;

    localparam int CB   = 12;
    localparam int OB   = 2;
    localparam int PB   = 8;
    localparam int SS   = 2;
    localparam int NLEV = 2 ** OB;
    // Elapsed clocks since window start at which an unfinished window gives up.
    localparam int TMO_ELAPSED = 2 ** CB - 1;

    logic          clk_200M = 1'b0;
    logic          reset_200M;
    logic          input_frequency;
    logic [PB-1:0] periods_i;
    logic [CB-1:0] compare_base_i;
    logic [CB-1:0] compare_step_i;
    logic [CB-1:0] sample_o;
    logic [OB-1:0] comparison_o;
    logic          sample_valid_o;
    logic          no_signal_o;

    frequency_discriminator #(
        .COUNT_BITS (CB),
        .OUTPUT_BITS(OB),
        .PERIOD_BITS(PB),
        .SYNC_STAGES(SS)
    ) dut (
        .clk_200M       (clk_200M),
        .reset_200M     (reset_200M),
        .input_frequency(input_frequency),
        .periods_i      (periods_i),
        .compare_base_i (compare_base_i),
        .compare_step_i (compare_step_i),
        .sample_o       (sample_o),
        .comparison_o   (comparison_o),
        .sample_valid_o (sample_valid_o),
        .no_signal_o    (no_signal_o)
    );

    always #5 clk_200M = ~clk_200M;

    int cyc = 0;
    always @(posedge clk_200M) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // Carrier / configuration controls written by the main sequence.
    bit car_en = 1'b0;
    bit car_idle;
    int car_period = 40;
    int cfg_periods = 5;
    int cfg_base = 198;
    int cfg_step = 2;

    // Reference model state: window start time, edges seen, periods for this window.
    bit m_meas = 1'b0;
    int m_t0 = 0;
    int m_edges = 0;
    int m_nlat = 1;
    int q_samp[$];
    int q_lvl[$];
    int mon_es, mon_el;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_level(input int s, input int b, input int st);
        int c;
        c = 0;
        for (int j = 0; j < NLEV - 1; j++) begin
            if (s < b + j * st) c++;
        end
        return c;
    endfunction

    // Called at each generated carrier rising edge, n = clock index of that edge.
    task automatic model_edge(input int n);
        int e, nxt;
        nxt = (periods_i == 0) ? 1 : int'(periods_i);
        if (m_meas && (n - m_t0) > TMO_ELAPSED) m_meas = 1'b0;
        if (!m_meas) begin
            m_meas  = 1'b1;
            m_t0    = n;
            m_edges = 0;
            m_nlat  = nxt;
            return;
        end
        e = n - m_t0;
        m_edges++;
        if (m_edges == m_nlat) begin
            q_samp.push_back(e);
            q_lvl.push_back(model_level(e, int'(compare_base_i), int'(compare_step_i)));
            m_t0    = n;
            m_edges = 0;
            m_nlat  = nxt;
        end else if (e == TMO_ELAPSED) begin
            m_meas = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_meas = 1'b0;
        q_samp.delete();
        q_lvl.delete();
    endtask

    // Carrier generator; configuration is applied mid-period (on the falling half).
    initial begin
        int p;
        input_frequency = 1'b0;
        car_idle        = 1'b1;
        periods_i       = PB'(cfg_periods);
        compare_base_i  = CB'(cfg_base);
        compare_step_i  = CB'(cfg_step);
        forever begin
            @(negedge clk_200M);
            if (car_en) begin
                car_idle = 1'b0;
                p = car_period;
                input_frequency = 1'b1;
                model_edge(cyc);
                repeat (p / 2) @(negedge clk_200M);
                input_frequency = 1'b0;
                periods_i      = PB'(cfg_periods);
                compare_base_i = CB'(cfg_base);
                compare_step_i = CB'(cfg_step);
                repeat (p - p / 2 - 1) @(negedge clk_200M);
            end else begin
                car_idle       = 1'b1;
                periods_i      = PB'(cfg_periods);
                compare_base_i = CB'(cfg_base);
                compare_step_i = CB'(cfg_step);
            end
        end
    end

    // Scoreboard monitor.
    always @(negedge clk_200M) begin
        if (sample_valid_o) begin
            if (q_samp.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_valid: got pulse with sample %0d, expected no pulse", sample_o);
            end else begin
                mon_es = q_samp.pop_front();
                mon_el = q_lvl.pop_front();
                chk("sb_sample", sample_o, mon_es);
                chk("sb_level", comparison_o, mon_el);
                chk("sb_no_signal", no_signal_o, 0);
            end
        end
    end

    task automatic wait_valid(input int budget, input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk_200M);
            k++;
        end while (!sample_valid_o && k < budget);
        if (!sample_valid_o) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: got no sample_valid_o within %0d cycles, expected a pulse", name, budget);
        end
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (!car_idle && k < budget) begin
            @(negedge clk_200M);
            k++;
        end
        if (!car_idle) begin
            n_checks++;
            n_errors++;
            $display("FAIL carrier_idle: got busy after %0d cycles, expected idle", budget);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_sample"}, sample_o, 0);
        chk({tag, "_level"}, comparison_o, 0);
        chk({tag, "_valid"}, sample_valid_o, 0);
        chk({tag, "_no_signal"}, no_signal_o, 1);
    endtask

    initial begin
        int tv, t0, exp_ns, k;
        reset_200M = 1'b1;
        repeat (4) @(negedge clk_200M);
        check_reset_values("rst_init");
        reset_200M = 1'b0;
        repeat (20) @(negedge clk_200M);
        chk("idle_no_signal", no_signal_o, 1);

        // Nominal: 5 periods of 40 clocks -> 200, level 1.
        car_en = 1'b1;
        wait_valid(600, "first_sample");
        chk("nom_sample", sample_o, 200);
        chk("nom_level", comparison_o, 1);
        chk("nom_no_signal", no_signal_o, 0);
        tv = cyc;
        wait_valid(400, "second_sample");
        chk("valid_spacing", cyc - tv, 200);

        // Carrier stops: timeout flags loss of signal, outputs hold.
        t0 = m_t0;
        car_en = 1'b0;
        exp_ns = t0 + SS + 2 + TMO_ELAPSED;
        k = 0;
        while (!no_signal_o && k < 6000) begin
            @(negedge clk_200M);
            k++;
        end
        chk("timeout_cycle", no_signal_o ? cyc : -1, exp_ns);
        chk("hold_sample", sample_o, 200);
        chk("hold_level", comparison_o, 1);

        // Restart after acquisition.
        car_en = 1'b1;
        wait_valid(1000, "restart_sample");
        chk("restart_sample", sample_o, 200);
        chk("restart_no_signal", no_signal_o, 0);

        // Faster and slower carriers.
        car_period = 39;
        wait_valid(600, "skip39a");
        wait_valid(600, "skip39b");
        wait_valid(600, "p39");
        chk("p39_sample", sample_o, 195);
        chk("p39_level", comparison_o, 3);
        car_period = 41;
        wait_valid(600, "skip41a");
        wait_valid(600, "skip41b");
        wait_valid(600, "p41");
        chk("p41_sample", sample_o, 205);
        chk("p41_level", comparison_o, 0);

        // periods_i change mid-window takes effect on the next window.
        car_period = 40;
        wait_valid(600, "skip40a");
        wait_valid(600, "skip40b");
        repeat (60) @(negedge clk_200M);
        cfg_periods = 10;
        wait_valid(600, "pchg_cur");
        chk("pchg_cur_sample", sample_o, 200);
        wait_valid(800, "pchg_next");
        chk("pchg_next_sample", sample_o, 400);

        // periods_i = 0 behaves as one period per sample.
        cfg_periods = 0;
        wait_valid(800, "skip0a");
        wait_valid(800, "skip0b");
        wait_valid(200, "p0_a");
        chk("p0_sample_a", sample_o, 40);
        wait_valid(200, "p0_b");
        chk("p0_sample_b", sample_o, 40);

        // Reset mid-measurement.
        cfg_periods = 5;
        wait_valid(600, "skip5a");
        wait_valid(600, "skip5b");
        repeat (70) @(negedge clk_200M);
        car_en = 1'b0;
        wait_idle(100);
        #2;
        reset_200M = 1'b1;
        model_reset();
        #1;
        check_reset_values("rst_mid");
        repeat (3) @(negedge clk_200M);
        reset_200M = 1'b0;
        repeat (5) @(negedge clk_200M);
        chk("post_rst_no_signal", no_signal_o, 1);
        car_en = 1'b1;
        wait_valid(600, "post_rst_sample");
        chk("post_rst_sample", sample_o, 200);
        chk("post_rst_level", comparison_o, 1);

        // Randomised carrier periods and configuration.
        repeat (25) begin
            repeat ($urandom_range(60, 500)) @(negedge clk_200M);
            car_period  = $urandom_range(20, 80);
            cfg_periods = $urandom_range(0, 6);
            cfg_base    = $urandom_range(0, 700);
            cfg_step    = $urandom_range(0, 200);
        end
        repeat (600) @(negedge clk_200M);
        car_en = 1'b0;
        wait_idle(100);
        repeat (20) @(negedge clk_200M);
        chk("sb_drained", q_samp.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/frequency_discriminator.md
FREQUENCY_DISCRIMINATOR -- requirements
Module: frequency_discriminator

Interface
REQ-001 SHALL have parameter COUNT_BITS, default 16, width of reference-clock period counter and sample_o.
REQ-002 SHALL have parameter OUTPUT_BITS, default 2, width of comparison_o; NUM_LEVELS = 2**OUTPUT_BITS.
REQ-003 SHALL have parameter PERIOD_BITS, default 8, width of periods_i.
REQ-004 SHALL have parameter SYNC_STAGES, default 2 (min 2), synchroniser depth for input_frequency.
REQ-005 SHALL have port clk_200M  input  1  reference clock; sole clock of the block.
REQ-006 SHALL have port reset_200M  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port input_frequency  input  1  asynchronous carrier under measurement.
REQ-008 SHALL have port periods_i  input  PERIOD_BITS  input periods per sample.
REQ-009 SHALL have port compare_base_i  input  COUNT_BITS  first threshold.
REQ-010 SHALL have port compare_step_i  input  COUNT_BITS  threshold spacing.
REQ-011 SHALL have port sample_o  output  COUNT_BITS  last measured reference-clock count.
REQ-012 SHALL have port comparison_o  output  OUTPUT_BITS  quantised frequency level.
REQ-013 SHALL have port sample_valid_o  output  1  one-cycle pulse on each new sample.
REQ-014 SHALL have port no_signal_o  output  1  high while no carrier is measured.

Function
REQ-015 SHALL pass input_frequency through SYNC_STAGES flops plus one history flop; edge = synchronised high AND history low.
REQ-016 SHALL implement FSM states ACQUIRE and MEASURE.
REQ-017 ACQUIRE: counters held at 0; on edge -> MEASURE, period counter <= 0, edge counter <= 0, periods_i latched (0 latched as 1).
REQ-018 MEASURE: period counter SHALL increment by 1 every cycle; edge counter SHALL increment on each edge.
REQ-019 MEASURE: on edge with edge counter + 1 == latched periods, SHALL set sample_o <= period counter + 1, pulse sample_valid_o, clear both counters, re-latch periods_i, and remain in MEASURE.
REQ-020 Capture SHALL compare the new sample with thresholds T_j = compare_base_i + j*compare_step_i, j = 0..NUM_LEVELS-2, computed without wrap (wider than COUNT_BITS).
REQ-021 comparison_o SHALL equal the count of j with new sample < T_j, so a higher frequency gives a higher code.
REQ-022 sample_o, comparison_o and sample_valid_o SHALL update in the same cycle.
REQ-023 compare_base_i and compare_step_i SHALL be sampled only at capture.
REQ-024 Latency: sample_valid_o SHALL assert SYNC_STAGES+2 cycles after the completing input rising edge reaches the first synchroniser flop.
REQ-025 Timeout: in MEASURE, if the period counter equals 2**COUNT_BITS-2 and that cycle completes no sample, the block SHALL go to ACQUIRE and set no_signal_o; sample_o and comparison_o hold; no valid pulse.
REQ-026 A completing edge on the timeout cycle SHALL take priority: the sample is captured, with no timeout.
REQ-027 no_signal_o SHALL clear in the cycle sample_valid_o pulses.
REQ-028 A periods_i change mid-measurement SHALL take effect only from the next sample.

Reset
REQ-029 reset_200M high SHALL immediately force: state ACQUIRE, all counters 0, synchroniser flops 0, sample_o 0, comparison_o 0, sample_valid_o 0, no_signal_o 1.
REQ-030 Reset asserted mid-measurement SHALL discard the partial count; after release, the first sample needs a fresh ACQUIRE edge.

Verification
REQ-031 periods_i=5, carrier period 40 clocks, base 198, step 2, OUTPUT_BITS=2 -> sample_o=200, comparison_o=1, valid pulses every 200 clocks, no_signal_o=0 after first sample.
REQ-032 Same setup, carrier period 39 -> sample_o=195, comparison_o=3; period 41 -> sample_o=205, comparison_o=0.
REQ-033 Carrier stopped after a valid sample (COUNT_BITS=16) -> no_signal_o=1 when the counter reaches 65534, sample_o holds 200, no valid pulse; carrier restarted -> first valid after ACQUIRE edge plus 5 periods.
REQ-034 periods_i changed 5->10 mid-measurement -> current sample=200, next sample=400.
REQ-035 periods_i=0, carrier period 40 -> every sample=40.
REQ-036 reset_200M pulsed mid-measurement -> all outputs at reset values immediately; first post-reset sample=200 after one ACQUIRE edge plus 5 periods.
